// File: rtl/xgriscv_hazard_ctrl_if.sv
// rtl/xgriscv_hazard_ctrl_if.sv - hazard/stall signal bundle between pipeline and hazard controller
interface xgriscv_hazard_ctrl_if;
  logic [4:0] rs1D;
  logic [4:0] rs2D;
  logic [4:0] rdE;
  logic       memreadE;
  logic       redirectE;
  logic       mreqM;
  logic       mreadyM;
  logic       pcenF;
  logic       stallD;
  logic       flushD;
  logic       stallE;
  logic       flushE;
  logic       stallM;
  logic       memerr;

  modport master (
    output rs1D, rs2D, rdE, memreadE, redirectE, mreqM, mreadyM,
    input  pcenF, stallD, flushD, stallE, flushE, stallM, memerr
  );

  modport slave (
    input  rs1D, rs2D, rdE, memreadE, redirectE, mreqM, mreadyM,
    output pcenF, stallD, flushD, stallE, flushE, stallM, memerr
  );
endinterface

// File: rtl/xgriscv_hazard_ctrl.sv
// rtl/xgriscv_hazard_ctrl.sv - pipeline stall/flush sequencing with bounded memory wait
// Optional stall/flush performance counters enabled by defining STALL_PERF_EN.
module xgriscv_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNTW        = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  xgriscv_hazard_ctrl_if.slave hz
`ifdef STALL_PERF_EN
  ,
  output logic [CNTW-1:0]      stallcnt,
  output logic [CNTW-1:0]      flushcnt
`endif
);

  localparam int WW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WW-1:0] WLAST = WW'(MEM_TIMEOUT - 1);

  typedef enum logic {RUN, MWAIT} state_t;

  state_t        state, state_n;
  logic [WW-1:0] wcnt, wcnt_n;
  logic          memerr_q, memerr_n;
  logic          loaduse, tmo, memwait;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= RUN;
      wcnt     <= '0;
      memerr_q <= 1'b0;
    end else begin
      state    <= state_n;
      wcnt     <= wcnt_n;
      memerr_q <= memerr_n;
    end
  end

  always_comb begin
    state_n   = state;
    wcnt_n    = wcnt;
    memerr_n  = 1'b0;
    loaduse   = hz.memreadE && (hz.rdE != 5'd0) &&
                ((hz.rdE == hz.rs1D) || (hz.rdE == hz.rs2D));
    tmo       = (state == MWAIT) && (wcnt == WLAST);
    memwait   = hz.mreqM && !hz.mreadyM && !tmo;
    hz.pcenF  = 1'b1;
    hz.stallD = 1'b0;
    hz.flushD = 1'b0;
    hz.stallE = 1'b0;
    hz.flushE = 1'b0;
    hz.stallM = 1'b0;

    // Outputs are forced to their idle values while reset is held.
    if (!reset) begin
      if (memwait) begin
        hz.pcenF  = 1'b0;
        hz.stallD = 1'b1;
        hz.stallE = 1'b1;
        hz.stallM = 1'b1;
      end else if (hz.redirectE) begin
        hz.flushD = 1'b1;
        hz.flushE = 1'b1;
      end else if (loaduse) begin
        hz.pcenF  = 1'b0;
        hz.stallD = 1'b1;
        hz.flushE = 1'b1;
      end
    end

    case (state)
      RUN: begin
        if (hz.mreqM && !hz.mreadyM) begin
          state_n = MWAIT;
          wcnt_n  = WW'(1);
        end
      end
      MWAIT: begin
        if (!hz.mreqM || hz.mreadyM) begin
          state_n = RUN;
          wcnt_n  = '0;
        end else if (tmo) begin
          state_n  = RUN;
          wcnt_n   = '0;
          memerr_n = 1'b1;
        end else if (wcnt != WLAST) begin
          wcnt_n = wcnt + WW'(1);
        end
      end
      default: begin
        state_n = RUN;
        wcnt_n  = '0;
      end
    endcase
  end

  assign hz.memerr = memerr_q;

`ifdef STALL_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stallcnt <= '0;
      flushcnt <= '0;
    end else begin
      if (!hz.pcenF)
        stallcnt <= stallcnt + CNTW'(1);
      if (hz.flushD || hz.flushE)
        flushcnt <= flushcnt + CNTW'(1);
    end
  end
`endif

endmodule
